traffic_collision: RTL and testbench
====================================

TRAFFIC_COLLISION -- requirements
Module: traffic_collision

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, meaning horizontal wrap width in pixels.
REQ-002 SHALL have parameter GRID_SIZE, default 32, meaning frog width and lane pitch unit in pixels.
REQ-003 SHALL have parameter CAR_W, default 64, meaning car width in pixels.
REQ-004 SHALL have parameter LANE_Y0, default 96, meaning y of lane 0; lane k is at LANE_Y0 + 64*k, k = 0..3.
REQ-005 SHALL have parameter HIT_FRAMES, default 60, meaning invulnerability length in frame ticks.
REQ-006 SHALL have port i_Clk, input, 1 bit: system clock; all logic is in this one clock domain.
REQ-007 SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port i_Frame_Tick, input, 1 bit: one-cycle pulse per video frame.
REQ-009 SHALL have port i_Frog_X, input, 10 bits: frog left edge, in pixels.
REQ-010 SHALL have port i_Frog_Y, input, 10 bits: frog top edge, in pixels.
REQ-011 SHALL have port i_Level, input, 4 bits: current level.
REQ-012 SHALL have port i_Restart, input, 1 bit: leaves GAME_OVER.
REQ-013 SHALL have port o_Car_X, output, 40 bits: packed car x positions, lane k in bits [10k+9:10k].
REQ-014 SHALL have port o_Hit, output, 1 bit: one-cycle pulse when a collision is accepted.
REQ-015 SHALL have port o_Lives, output, 2 bits: remaining lives.
REQ-016 SHALL have port o_Game_Over, output, 1 bit: high while in GAME_OVER.

Function
REQ-017 SHALL implement the states PLAY, CHECK, HIT_WAIT and GAME_OVER.
REQ-018 SHALL, in PLAY or HIT_WAIT on i_Frame_Tick, advance every car by step = clamp(i_Level, 1, 7) pixels.
- Even lanes move right; odd lanes move left.
REQ-019 SHALL wrap a right-moving car as follows: if x + step >= H_DISPLAY, then x <= x + step - H_DISPLAY.
REQ-020 SHALL wrap a left-moving car as follows: if x < step, then x <= x + H_DISPLAY - step.
- Car x therefore always stays in 0..H_DISPLAY-1.
REQ-021 SHALL compute all additions at 11-bit width to avoid overflow.
REQ-022 SHALL move from PLAY to CHECK one cycle after the position update.
- CHECK evaluates collision on the updated o_Car_X (collision latency = 1 cycle after tick).
REQ-023 SHALL detect a collision in lane k when all of the following hold: i_Frog_Y == lane_y(k), i_Frog_X < car_x + CAR_W, and car_x < i_Frog_X + GRID_SIZE.
- The compare is unsigned 11-bit; the wrapped car tail is not considered.
REQ-024 SHALL, on a collision in CHECK with o_Lives > 1: decrement o_Lives, pulse o_Hit for one cycle, load the frame counter with HIT_FRAMES, and go to HIT_WAIT.
REQ-025 SHALL, on a collision in CHECK with o_Lives == 1: set o_Lives = 0, pulse o_Hit, and go to GAME_OVER.
REQ-026 SHALL return from CHECK to PLAY when there is no collision.
REQ-027 SHALL report at most one hit per CHECK, even if multiple lanes collide.
REQ-028 SHALL, in HIT_WAIT, keep cars moving, ignore collisions, decrement the counter on each tick, and return to PLAY on the tick where the counter reaches 0.
REQ-029 SHALL, in GAME_OVER, freeze cars, hold o_Game_Over = 1, and ignore i_Frame_Tick.
REQ-030 SHALL, in GAME_OVER with i_Restart = 1, set o_Lives = 3, restore initial car positions, and go to PLAY on the next cycle.
REQ-031 SHALL ignore i_Restart outside GAME_OVER.
REQ-032 SHALL resolve an i_Frame_Tick arriving while in CHECK by applying it on the following cycle.
- No tick is lost; ticks are at least 2 cycles apart by contract.

Reset
REQ-033 SHALL apply the following reset values: state PLAY; o_Lives = 3; o_Hit = 0; o_Game_Over = 0; frame counter = 0; car x(k) = 160*k, i.e. 0/160/320/480.
REQ-034 SHALL let i_Reset override every state, including mid-HIT_WAIT and GAME_OVER, taking effect on the next clock edge.

Structure
REQ-035 SHALL place H_DISPLAY, GRID_SIZE, CAR_W, LANE_Y0, the lane pitch (64), the state encodings and the start lives (3) in the shared package frogger_pkg.
REQ-036 SHALL instantiate one lane_car sub-module per lane.
- lane_car holds the position register, step and wrap, with a direction parameter and an initial-x parameter.
REQ-037 SHALL keep the FSM, collision compare and lives counter in traffic_collision.

Verification
REQ-038 SHALL cover wrap right: lane 0 at x = 636, level 7, one tick -> x = 3.
REQ-039 SHALL cover wrap left: lane 1 at x = 2, level 5, one tick -> x = 637.
REQ-040 SHALL cover a hit: frog (160, 96), lane 0 car at x = 130 after tick -> o_Hit pulses 1 cycle after tick, lives 3 -> 2; a further overlap for the next 59 ticks -> no hit.
REQ-041 SHALL cover a miss: frog (200, 96), car at x = 136 (edge touching: 136 + 64 = 200) -> no hit.
REQ-042 SHALL cover game over: three accepted hits -> lives 0, o_Game_Over = 1, cars frozen over 5 ticks; then i_Restart -> lives 3, cars 0/160/320/480.
REQ-043 SHALL cover reset mid-HIT_WAIT: i_Reset after 10 invulnerable ticks -> all reset values next cycle; the first overlap after reset is hit-detected.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared constants, FSM encoding and helpers for the frogger traffic logic.
package frogger_pkg;

  localparam int unsigned H_DISPLAY    = 640;
  localparam int unsigned GRID_SIZE    = 32;
  localparam int unsigned CAR_W        = 64;
  localparam int unsigned LANE_Y0      = 96;
  localparam int unsigned LANE_PITCH   = 64;
  localparam int unsigned START_LIVES  = 3;
  localparam int unsigned NUM_LANES    = 4;
  localparam int unsigned X_W          = 10;
  localparam int unsigned ADD_W        = 11;
  localparam int unsigned CAR_INIT_GAP = 160;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_CHECK     = 2'd1,
    ST_HIT_WAIT  = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  // Car speed in pixels per frame: level clamped to 1..7.
  function automatic logic [2:0] level_step(input logic [3:0] level);
    if (level == 4'd0) return 3'd1;
    if (level > 4'd7) return 3'd7;
    return level[2:0];
  endfunction

endpackage

// File: rtl/lane_car.sv
// One lane's car: x position register with per-frame step and horizontal wrap.
module lane_car #(
  parameter int unsigned H_DISPLAY = 640,
  parameter bit          MOVE_LEFT = 1'b0,
  parameter int unsigned INIT_X    = 0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Load,
  input  logic       i_Move,
  input  logic [2:0] i_Step,
  output logic [9:0] o_X
);

  logic [10:0] x_ext;
  logic [10:0] step_ext;
  logic [10:0] h_ext;
  logic [10:0] sum;
  logic [10:0] next_x;

  // Next position, computed 11 bits wide so x + H_DISPLAY cannot overflow.
  always_comb begin
    x_ext    = {1'b0, o_X};
    step_ext = 11'(i_Step);
    h_ext    = 11'(H_DISPLAY);
    sum      = x_ext + step_ext;
    next_x   = sum;
    if (MOVE_LEFT) begin
      if (x_ext < step_ext) next_x = x_ext + h_ext - step_ext;
      else                  next_x = x_ext - step_ext;
    end else if (sum >= h_ext) begin
      next_x = sum - h_ext;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Load) o_X <= 10'(INIT_X);
    else if (i_Move)       o_X <= next_x[9:0];
  end

endmodule

// File: rtl/traffic_collision.sv
// Frogger traffic: four moving car lanes, frog collision check, lives and game-over FSM.
module traffic_collision #(
  parameter int unsigned H_DISPLAY  = frogger_pkg::H_DISPLAY,
  parameter int unsigned GRID_SIZE  = frogger_pkg::GRID_SIZE,
  parameter int unsigned CAR_W      = frogger_pkg::CAR_W,
  parameter int unsigned LANE_Y0    = frogger_pkg::LANE_Y0,
  parameter int unsigned HIT_FRAMES = 60
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Frame_Tick,
  input  logic [9:0]  i_Frog_X,
  input  logic [9:0]  i_Frog_Y,
  input  logic [3:0]  i_Level,
  input  logic        i_Restart,
  output logic [39:0] o_Car_X,
  output logic        o_Hit,
  output logic [1:0]  o_Lives,
  output logic        o_Game_Over
);
  import frogger_pkg::*;

  localparam int unsigned CNT_W = $clog2(HIT_FRAMES + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       lives_next;
  logic             hit_next;
  logic             go_next;
  logic             pend, pend_next;
  logic             tick_c;
  logic             move_c;
  logic             load_c;
  logic [2:0]       step_c;
  logic [3:0]       lane_hit_c;
  logic             any_hit_c;

  assign step_c    = level_step(i_Level);
  assign tick_c    = i_Frame_Tick | pend;
  assign any_hit_c = |lane_hit_c;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam bit          LEFT   = (k % 2) == 1;
    localparam logic [9:0]  LANE_Y = 10'(LANE_Y0 + LANE_PITCH * k);
    logic [10:0] car_x;
    logic [10:0] frog_x;

    lane_car #(
      .H_DISPLAY (H_DISPLAY),
      .MOVE_LEFT (LEFT),
      .INIT_X    (CAR_INIT_GAP * k)
    ) u_car (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Load  (load_c),
      .i_Move  (move_c),
      .i_Step  (step_c),
      .o_X     (o_Car_X[10*k +: 10])
    );

    // Head-only overlap; the wrapped-around tail of a car is ignored.
    assign car_x         = {1'b0, o_Car_X[10*k +: 10]};
    assign frog_x        = {1'b0, i_Frog_X};
    assign lane_hit_c[k] = (i_Frog_Y == LANE_Y) &&
                           (frog_x < car_x + 11'(CAR_W)) &&
                           (car_x < frog_x + 11'(GRID_SIZE));
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= ST_PLAY;
      cnt         <= '0;
      o_Lives     <= 2'(START_LIVES);
      o_Hit       <= 1'b0;
      o_Game_Over <= 1'b0;
      pend        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      o_Lives     <= lives_next;
      o_Hit       <= hit_next;
      o_Game_Over <= go_next;
      pend        <= pend_next;
    end
  end

  // A tick landing in CHECK is parked in pend and consumed the next cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lives_next = o_Lives;
    hit_next   = 1'b0;
    go_next    = o_Game_Over;
    pend_next  = 1'b0;
    move_c     = 1'b0;
    load_c     = 1'b0;
    case (state)
      ST_PLAY: begin
        if (tick_c) begin
          move_c     = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        pend_next = i_Frame_Tick;
        if (any_hit_c) begin
          hit_next = 1'b1;
          if (o_Lives > 2'd1) begin
            lives_next = o_Lives - 2'd1;
            cnt_next   = CNT_W'(HIT_FRAMES);
            state_next = ST_HIT_WAIT;
          end else begin
            lives_next = 2'd0;
            go_next    = 1'b1;
            state_next = ST_GAME_OVER;
          end
        end else begin
          state_next = ST_PLAY;
        end
      end
      ST_HIT_WAIT: begin
        if (tick_c) begin
          move_c = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            cnt_next   = '0;
            state_next = ST_PLAY;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
      ST_GAME_OVER: begin
        if (i_Restart) begin
          load_c     = 1'b1;
          lives_next = 2'(START_LIVES);
          go_next    = 1'b0;
          state_next = ST_PLAY;
        end
      end
      default: state_next = ST_PLAY;
    endcase
  end

endmodule

// File: tb/tb_traffic_collision.sv
// Directed, table-driven bench for traffic_collision.
module tb_traffic_collision;

  logic        clk = 1'b0;
  logic        i_Reset;
  logic        i_Frame_Tick;
  logic [9:0]  i_Frog_X;
  logic [9:0]  i_Frog_Y;
  logic [3:0]  i_Level;
  logic        i_Restart;
  logic [39:0] o_Car_X;
  logic        o_Hit;
  logic [1:0]  o_Lives;
  logic        o_Game_Over;

  traffic_collision dut (
    .i_Clk        (clk),
    .i_Reset      (i_Reset),
    .i_Frame_Tick (i_Frame_Tick),
    .i_Frog_X     (i_Frog_X),
    .i_Frog_Y     (i_Frog_Y),
    .i_Level      (i_Level),
    .i_Restart    (i_Restart),
    .o_Car_X      (o_Car_X),
    .o_Hit        (o_Hit),
    .o_Lives      (o_Lives),
    .o_Game_Over  (o_Game_Over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] fx;
    logic [9:0] fy;
    int         exp_hit;
    int         exp_lives;
  } coll_vec_t;

  typedef struct {
    logic [3:0] lvl;
    int         exp_step;
  } step_vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int m[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m[0] = 0; m[1] = 160; m[2] = 320; m[3] = 480;
  endtask

  task automatic model_move(input int s);
    for (int k = 0; k < 4; k++)
      m[k] = (k % 2 == 0) ? (m[k] + s) % 640 : (m[k] + 640 - s) % 640;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    cyc();
    i_Reset = 1'b0;
    model_reset();
  endtask

  task automatic check_cars(input string name);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_lane%0d", name, k), int'(o_Car_X[10*k +: 10]), m[k]);
  endtask

  // One frame tick; returns o_Hit sampled the cycle after the tick.
  task automatic tick(input logic [3:0] lvl, input int s, input bit moves, output logic hit);
    i_Level      = lvl;
    i_Frame_Tick = 1'b1;
    cyc();
    i_Frame_Tick = 1'b0;
    if (moves) model_move(s);
    cyc();
    hit = o_Hit;
    cyc();
  endtask

  task automatic advance(input int total);
    int   rem;
    int   s;
    logic h;
    rem = total;
    i_Frog_Y = 10'd0;
    while (rem > 0) begin
      s = (rem > 7) ? 7 : rem;
      tick(4'(s), s, 1'b1, h);
      rem -= s;
    end
  endtask

  task automatic score_hit(input string name, input int exp_lives);
    logic h;
    i_Frog_Y = 10'd96;
    i_Frog_X = 10'((m[0] + 1) % 640);
    tick(4'd1, 1, 1'b1, h);
    check({name, "_hit"}, int'(h), 1);
    check({name, "_lives"}, int'(o_Lives), exp_lives);
    i_Frog_Y = 10'd0;
  endtask

  task automatic wait_out_hit();
    logic h;
    for (int i = 0; i < 60; i++) tick(4'd1, 1, 1'b1, h);
  endtask

  coll_vec_t cv[9];
  step_vec_t sv[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic h;
    int   hits;

    cv[0] = '{10'd0,   10'd96,  1, 2};
    cv[1] = '{10'd200, 10'd96,  0, 3};
    cv[2] = '{10'd140, 10'd160, 1, 2};
    cv[3] = '{10'd127, 10'd160, 0, 3};
    cv[4] = '{10'd385, 10'd224, 0, 3};
    cv[5] = '{10'd384, 10'd224, 1, 2};
    cv[6] = '{10'd479, 10'd288, 1, 2};
    cv[7] = '{10'd300, 10'd100, 0, 3};
    cv[8] = '{10'd0,   10'd288, 0, 3};

    sv[0] = '{4'd0, 1};
    sv[1] = '{4'd1, 1};
    sv[2] = '{4'd4, 4};
    sv[3] = '{4'd7, 7};
    sv[4] = '{4'd8, 7};
    sv[5] = '{4'd15, 7};

    i_Reset = 1'b1; i_Frame_Tick = 1'b0; i_Frog_X = '0; i_Frog_Y = '0;
    i_Level = 4'd1; i_Restart = 1'b0;
    cyc(); cyc();
    i_Reset = 1'b0;
    model_reset();

    check("rst_lives", int'(o_Lives), 3);
    check("rst_hit", int'(o_Hit), 0);
    check("rst_game_over", int'(o_Game_Over), 0);
    check("rst_car0", int'(o_Car_X[9:0]), 0);
    check("rst_car1", int'(o_Car_X[19:10]), 160);
    check("rst_car2", int'(o_Car_X[29:20]), 320);
    check("rst_car3", int'(o_Car_X[39:30]), 480);

    // Level clamping of the per-frame step
    for (int i = 0; i < 6; i++) begin
      tick(sv[i].lvl, sv[i].exp_step, 1'b1, h);
      check_cars($sformatf("step%0d", i));
    end

    // Single-tick collision vectors from the reset positions
    for (int i = 0; i < 9; i++) begin
      do_reset();
      i_Frog_X = cv[i].fx;
      i_Frog_Y = cv[i].fy;
      tick(4'd1, 1, 1'b1, h);
      check($sformatf("coll%0d_hit", i), int'(h), cv[i].exp_hit);
      check($sformatf("coll%0d_lives", i), int'(o_Lives), cv[i].exp_lives);
    end

    // Right wrap
    do_reset();
    advance(636);
    check("wrapr_pre", int'(o_Car_X[9:0]), 636);
    tick(4'd7, 7, 1'b1, h);
    check("wrapr_x", int'(o_Car_X[9:0]), 3);
    check_cars("wrapr");

    // Left wrap
    do_reset();
    advance(158);
    check("wrapl_pre", int'(o_Car_X[19:10]), 2);
    tick(4'd5, 5, 1'b1, h);
    check("wrapl_x", int'(o_Car_X[19:10]), 637);

    // Hit, invulnerability window, and re-hit right after it ends
    do_reset();
    advance(129);
    i_Frog_X = 10'd160;
    i_Frog_Y = 10'd96;
    tick(4'd1, 1, 1'b1, h);
    check("hit_pulse", int'(h), 1);
    check("hit_car0", int'(o_Car_X[9:0]), 130);
    check("hit_lives", int'(o_Lives), 2);
    check("hit_pulse_width", int'(o_Hit), 0);
    hits = 0;
    for (int i = 0; i < 59; i++) begin
      tick(4'd1, 1, 1'b1, h);
      if (h) hits++;
    end
    check("invuln_hits", hits, 0);
    check("invuln_lives", int'(o_Lives), 2);
    tick(4'd1, 1, 1'b1, h);
    check("invuln_last_tick", int'(h), 0);
    tick(4'd1, 1, 1'b1, h);
    check("rehit_pulse", int'(h), 1);
    check("rehit_lives", int'(o_Lives), 1);
    check("rehit_car0", int'(o_Car_X[9:0]), 191);
    i_Frog_Y = 10'd0;

    // Restart ignored outside GAME_OVER
    i_Restart = 1'b1;
    cyc();
    i_Restart = 1'b0;
    cyc();
    check("restart_ignored_lives", int'(o_Lives), 1);
    check_cars("restart_ignored");

    // Miss with edges just touching
    do_reset();
    advance(135);
    i_Frog_X = 10'd200;
    i_Frog_Y = 10'd96;
    tick(4'd1, 1, 1'b1, h);
    check("miss_car0", int'(o_Car_X[9:0]), 136);
    check("miss_hit", int'(h), 0);
    check("miss_lives", int'(o_Lives), 3);

    // Game over, frozen cars, then restart
    do_reset();
    score_hit("go1", 2);
    wait_out_hit();
    score_hit("go2", 1);
    wait_out_hit();
    score_hit("go3", 0);
    check("go_flag", int'(o_Game_Over), 1);
    i_Frog_Y = 10'd96;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      i_Frog_X = o_Car_X[9:0];
      tick(4'd7, 7, 1'b0, h);
      if (h) hits++;
    end
    i_Frog_Y = 10'd0;
    check("go_no_hits", hits, 0);
    check_cars("go_frozen");
    check("go_flag_held", int'(o_Game_Over), 1);
    i_Restart = 1'b1;
    cyc();
    i_Restart = 1'b0;
    model_reset();
    check("restart_lives", int'(o_Lives), 3);
    check("restart_go", int'(o_Game_Over), 0);
    check_cars("restart");
    tick(4'd3, 3, 1'b1, h);
    check_cars("restart_play");

    // Reset in the middle of HIT_WAIT
    do_reset();
    score_hit("rw1", 2);
    for (int i = 0; i < 10; i++) tick(4'd1, 1, 1'b1, h);
    i_Reset = 1'b1;
    cyc();
    i_Reset = 1'b0;
    model_reset();
    check("rw_lives", int'(o_Lives), 3);
    check("rw_hit", int'(o_Hit), 0);
    check("rw_go", int'(o_Game_Over), 0);
    check_cars("rw_cars");
    score_hit("rw2", 2);

    // Back-to-back ticks: second lands in CHECK and is deferred, not lost
    do_reset();
    i_Frog_Y = 10'd0;
    i_Level = 4'd2;
    i_Frame_Tick = 1'b1;
    cyc();
    cyc();
    i_Frame_Tick = 1'b0;
    model_move(2);
    model_move(2);
    cyc(); cyc(); cyc();
    check_cars("deferred_tick");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
